// File: rtl/phase_seq_scheduler.sv
// Sweeps one phase-measurement engine over Va, Vb, Vc and latches each result.
// Define PHASE_SETTLE_EN to hold SETTLE_CYC cycles after every channel switch.
module phase_seq_scheduler #(
  parameter int M          = 14,
  parameter int TIMEOUT    = 1000,
  parameter int SETTLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [M-1:0] Vref,
  input  logic signed [M-1:0] Va,
  input  logic signed [M-1:0] Vb,
  input  logic signed [M-1:0] Vc,
  output logic signed [M-1:0] meas_vref,
  output logic signed [M-1:0] meas_vin,
  output logic                meas_start,
  input  logic                meas_done,
  input  logic [15:0]         meas_phase,
  output logic [15:0]         phase_a,
  output logic [15:0]         phase_b,
  output logic [15:0]         phase_c,
  output logic [2:0]          valid,
  output logic [2:0]          timeout_err,
  output logic                busy,
  output logic                sweep_done
);

  if (TIMEOUT < 1 || TIMEOUT > 65535 ||
      SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_param
    $error("phase_seq_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    STORE,
    NEXT
`ifdef PHASE_SETTLE_EN
    , SETTLE
`endif
  } state_e;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

`ifdef PHASE_SETTLE_EN
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam state_e     LAUNCH      = SETTLE;
  logic [7:0] settle_q, settle_d;
`else
  localparam state_e     LAUNCH      = START;
`endif

  state_e      state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] pa_q, pa_d;
  logic [15:0] pb_q, pb_d;
  logic [15:0] pc_q, pc_d;
  logic [2:0]  valid_q, valid_d;
  logic [2:0]  terr_q, terr_d;
  logic [2:0]  sel;

  assign sel = 3'b001 << ch_q;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    wait_d     = wait_q;
    pa_d       = pa_q;
    pb_d       = pb_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    terr_d     = terr_q;
    meas_start = 1'b0;
    sweep_done = 1'b0;
`ifdef PHASE_SETTLE_EN
    settle_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (en) begin
          ch_d    = '0;
          state_d = LAUNCH;
        end
      end
`ifdef PHASE_SETTLE_EN
      SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = START;
        else settle_d = settle_q + 8'd1;
      end
`endif
      START: begin
        meas_start = 1'b1;
        wait_d     = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // done has priority over an expiring timeout in the same cycle
        if (meas_done) begin
          if (sel[0]) pa_d = meas_phase;
          if (sel[1]) pb_d = meas_phase;
          if (sel[2]) pc_d = meas_phase;
          valid_d = valid_q | sel;
          terr_d  = terr_q & ~sel;
          state_d = STORE;
        end else if (wait_q == WAIT_LAST) begin
          valid_d = valid_q & ~sel;
          terr_d  = terr_q | sel;
          state_d = NEXT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      STORE: state_d = NEXT;
      NEXT: begin
        if (ch_q == 2'd2) begin
          sweep_done = 1'b1;
          ch_d       = '0;
          state_d    = en ? LAUNCH : IDLE;
        end else begin
          ch_d    = ch_q + 2'd1;
          state_d = LAUNCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      wait_q   <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
      pc_q     <= '0;
      valid_q  <= '0;
      terr_q   <= '0;
`ifdef PHASE_SETTLE_EN
      settle_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      wait_q   <= wait_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      terr_q   <= terr_d;
`ifdef PHASE_SETTLE_EN
      settle_q <= settle_d;
`endif
    end
  end

  always_comb begin
    case (ch_q)
      2'd1:    meas_vin = Vb;
      2'd2:    meas_vin = Vc;
      default: meas_vin = Va;
    endcase
  end

  assign meas_vref   = Vref;
  assign phase_a     = pa_q;
  assign phase_b     = pb_q;
  assign phase_c     = pc_q;
  assign valid       = valid_q;
  assign timeout_err = terr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_phase_seq_scheduler.sv
// Self-checking bench for phase_seq_scheduler: timeline model plus engine stub.
// Works with or without PHASE_SETTLE_EN defined.
module tb_phase_seq_scheduler;
  localparam int M  = 14;
  localparam int T  = 16;
  localparam int SC = 4;
`ifdef PHASE_SETTLE_EN
  localparam int S = SC;
`else
  localparam int S = 0;
`endif

  logic clk = 1'b0;
  logic rst, en;
  logic signed [M-1:0] Vref, Va, Vb, Vc;
  logic signed [M-1:0] meas_vref, meas_vin;
  logic meas_start;
  logic meas_done = 1'b0;
  logic [15:0] meas_phase = '0;
  logic [15:0] phase_a, phase_b, phase_c;
  logic [2:0] valid, timeout_err;
  logic busy, sweep_done;

  int checks = 0;
  int errors = 0;
  int dly [3];
  logic [15:0] phv [3];
  int stray_n = 0;

  always #5 clk = ~clk;

  phase_seq_scheduler #(
    .M(M), .TIMEOUT(T), .SETTLE_CYC(SC)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .Vref(Vref), .Va(Va), .Vb(Vb), .Vc(Vc),
    .meas_vref(meas_vref), .meas_vin(meas_vin),
    .meas_start(meas_start), .meas_done(meas_done),
    .meas_phase(meas_phase),
    .phase_a(phase_a), .phase_b(phase_b), .phase_c(phase_c),
    .valid(valid), .timeout_err(timeout_err),
    .busy(busy), .sweep_done(sweep_done)
  );

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endfunction

  function automatic int chan_of(logic signed [M-1:0] v);
    if (v == Va) return 0;
    if (v == Vb) return 1;
    return 2;
  endfunction

  // engine stub: done dly[ch] cycles after start (0 = never)
  always @(negedge clk) begin : engine
    int e_cnt, e_d, stray_seen;
    bit e_act, e_done;
    logic [15:0] e_ph;
    e_done = 1'b0;
    if (rst) begin
      e_act = 1'b0;
    end else if (meas_start) begin
      e_act = 1'b1;
      e_cnt = 0;
      e_d   = dly[chan_of(meas_vin)];
      e_ph  = phv[chan_of(meas_vin)];
    end else if (e_act) begin
      e_cnt++;
      if (e_d > 0 && e_cnt == e_d) begin
        e_done = 1'b1;
        e_act  = 1'b0;
      end else if (e_cnt > T + 4) begin
        e_act = 1'b0;
      end
    end
    if (stray_n != stray_seen) begin
      e_done     = 1'b1;
      stray_seen = stray_n;
    end
    #1;
    meas_done  = e_done;
    meas_phase = e_ph;
  end

  // timeline model: each attempt is planned from its start cycle
  int cyc = 0;
  bit m_run = 0;
  bit m_ok = 0;
  int m_ch = 0, m_s = -1, m_u = -1, m_n = -1;
  logic [15:0] m_ph [3] = '{default: 16'd0};
  logic [2:0] m_val = '0, m_terr = '0;

  function automatic void plan();
    int d;
    d    = dly[m_ch];
    m_s  = cyc + S;
    m_ok = (d >= 1 && d <= T);
    if (m_ok) begin
      m_u = m_s + d + 1;
      m_n = m_s + d + 2;
    end else begin
      m_u = m_s + T + 1;
      m_n = m_u;
    end
  endfunction

  always @(negedge clk) begin : model
    logic signed [M-1:0] vexp;
    cyc++;
    if (rst) begin
      m_run  = 0;
      m_ch   = 0;
      m_ph   = '{default: 16'd0};
      m_val  = '0;
      m_terr = '0;
    end else begin
      if (m_run && cyc == m_n + 1) begin
        if (m_ch < 2) begin
          m_ch++;
          plan();
        end else begin
          m_ch = 0;
          if (en) plan();
          else m_run = 0;
        end
      end else if (!m_run && en) begin
        m_run = 1;
        m_ch  = 0;
        plan();
      end
      if (m_run && cyc == m_u) begin
        if (m_ok) begin
          m_ph[m_ch]   = phv[m_ch];
          m_val[m_ch]  = 1'b1;
          m_terr[m_ch] = 1'b0;
        end else begin
          m_val[m_ch]  = 1'b0;
          m_terr[m_ch] = 1'b1;
        end
      end
    end
    vexp = (m_ch == 0) ? Va : (m_ch == 1) ? Vb : Vc;
    chk("busy", busy, m_run);
    chk("meas_start", meas_start, m_run && cyc == m_s);
    chk("sweep_done", sweep_done,
        m_run && cyc == m_n && m_ch == 2);
    chk("meas_vin", meas_vin, vexp);
    chk("meas_vref", meas_vref, Vref);
    chk("phase_a", phase_a, m_ph[0]);
    chk("phase_b", phase_b, m_ph[1]);
    chk("phase_c", phase_c, m_ph[2]);
    chk("valid", valid, m_val);
    chk("timeout_err", timeout_err, m_terr);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_sd(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sweep_done && n < 400);
    chk("wait_sweep_done", sweep_done, 1'b1);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!meas_start && n < 200);
    chk("wait_start", meas_start, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk("wait_idle", busy, 1'b0);
  endtask

  initial begin
    int n, k;
    rst  = 1'b1;
    en   = 1'b0;
    Vref = 14'sd100;
    Va   = 14'sd1000;
    Vb   = -14'sd2000;
    Vc   = 14'sd3000;
    dly  = '{5, 5, 5};
    phv  = '{16'd120, 16'd240, 16'd0};
    tick();
    tick();
    chk("rst_phase_a", phase_a, 0);
    chk("rst_valid", valid, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vin", meas_vin, Va);
    rst = 1'b0;
    tick();

    // normal sweeps, done 5 cycles after start
    en = 1'b1;
    wait_sd(n);
    wait_sd(n);
    chk("period_d5", n, 24 + 3 * S);
    en = 1'b0;
    wait_idle();
    chk("t1_phase_a", phase_a, 120);
    chk("t1_phase_b", phase_b, 240);
    chk("t1_phase_c", phase_c, 0);
    chk("t1_valid", valid, 3'b111);
    chk("t1_terr", timeout_err, 3'b000);

    // fastest sweep
    dly = '{1, 1, 1};
    en  = 1'b1;
    wait_sd(n);
    wait_sd(n);
    chk("period_fast", n, 12 + 3 * S);
    en = 1'b0;
    wait_idle();

    // ch1 never answers
    dly = '{5, 0, 5};
    phv = '{16'd121, 16'd999, 16'd1};
    en  = 1'b1;
    wait_start(n);
    wait_start(n);
    wait_start(n);
    chk("timeout_gap", n, T + 2 + S);
    en = 1'b0;
    wait_sd(n);
    wait_idle();
    chk("t2_terr", timeout_err, 3'b010);
    chk("t2_valid", valid, 3'b101);
    chk("t2_phase_a", phase_a, 121);
    chk("t2_phase_b", phase_b, 240);
    chk("t2_phase_c", phase_c, 1);

    // done on the last WAIT cycle vs one cycle too late
    dly = '{T, T, T + 1};
    phv = '{16'd7, 16'd8, 16'd9};
    en  = 1'b1;
    wait_sd(n);
    en = 1'b0;
    wait_idle();
    chk("t3_phase_a", phase_a, 7);
    chk("t3_phase_b", phase_b, 8);
    chk("t3_phase_c", phase_c, 1);
    chk("t3_valid", valid, 3'b011);
    chk("t3_terr", timeout_err, 3'b100);

    // en dropped during ch0 WAIT, then stray done in IDLE
    dly = '{5, 5, 5};
    phv = '{16'd50, 16'd60, 16'd70};
    en  = 1'b1;
    wait_start(n);
    tick();
    tick();
    en = 1'b0;
    wait_sd(n);
    tick();
    chk("t4_busy", busy, 0);
    chk("t4_phase_a", phase_a, 50);
    chk("t4_phase_b", phase_b, 60);
    chk("t4_phase_c", phase_c, 70);
    stray_n++;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_stray_phase_a", phase_a, 50);
    chk("t4_stray_valid", valid, 3'b111);
    chk("t4_stray_busy", busy, 0);

    // async reset in ch1 WAIT
    en = 1'b1;
    wait_start(n);
    wait_start(n);
    tick();
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("t5_phase_a", phase_a, 0);
    chk("t5_phase_b", phase_b, 0);
    chk("t5_valid", valid, 0);
    chk("t5_terr", timeout_err, 0);
    chk("t5_busy", busy, 0);
    chk("t5_start", meas_start, 0);
    chk("t5_sweep_done", sweep_done, 0);
    chk("t5_vin", meas_vin, Va);
    en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("t5_idle", busy, 0);

    // channel switch to start spacing
    en = 1'b1;
    wait_start(n);
    k = 0;
    while (meas_vin == Va && k < 50) begin
      tick();
      k++;
    end
    k = 0;
    while (!meas_start && k < 50) begin
      tick();
      k++;
    end
    chk("settle_gap", k, S);
    en = 1'b0;
    wait_sd(n);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
